// File: rtl/stream_window_if.sv
// Pixel-stream / window bus between the line source, stream_window and the MAC stage.
// The slave view belongs to stream_window; the master view drives pixels and observes windows.
interface stream_window_if #(
    parameter int IMG_WIDTH = 16,
    parameter int IMG_NB    = 3
);
    logic [IMG_WIDTH-1:0]        pix;
    logic                        pix_val;
    logic                        pix_last;
    logic                        pix_rdy;
    logic [IMG_WIDTH*IMG_NB-1:0] img;
    logic                        val;
    logic                        last;

    modport master (
        output pix, pix_val, pix_last,
        input  pix_rdy, img, val, last
    );

    modport slave (
        input  pix, pix_val, pix_last,
        output pix_rdy, img, val, last
    );
endinterface

// File: rtl/stream_window.sv
// Sliding-window generator: packs IMG_NB consecutive same-row pixels into one window per beat.
// Define STREAM_WINDOW_ZERO_PAD_EN for same-size mode (zero halo at row edges, FLUSH after each row).
module stream_window #(
    parameter int IMG_WIDTH = 16,
    parameter int IMG_NB    = 3
) (
    input  logic            clk,
    input  logic            rst,
    stream_window_if.slave  bus
);
    localparam int H   = (IMG_NB - 1) / 2;
    localparam int CW  = $clog2(IMG_NB + 1);
    localparam int SRW = IMG_WIDTH * IMG_NB;
    localparam logic [CW-1:0] COUNT_MAX = CW'(IMG_NB);
`ifdef STREAM_WINDOW_ZERO_PAD_EN
    // The centre pixel trails the newest pixel by H, so windows start H beats into a row.
    localparam logic [CW-1:0] EMIT_IDX = CW'(H);
    localparam int FW = (H > 1) ? $clog2(H) : 1;
    localparam logic [FW-1:0] FLUSH_END = FW'(H - 1);
`else
    localparam logic [CW-1:0] EMIT_IDX = CW'(IMG_NB - 1);
`endif

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q;
    logic [SRW-1:0]        sr_q;
    logic [SRW-1:0]        shifted;
    logic [SRW-1:0]        img_q;
    logic                  val_q, last_q, rdy_q;
    logic                  accept, shift_en, emit, emit_last, clear_row, rdy_d;
    logic [IMG_WIDTH-1:0]  shift_in;
`ifdef STREAM_WINDOW_ZERO_PAD_EN
    logic [FW-1:0]         flush_q;
`endif

    assign accept  = bus.pix_val && rdy_q;
    // New pixel lands in the top slot; everything else moves one slot toward slot 0.
    assign shifted = {shift_in, sr_q[SRW-1:IMG_WIDTH]};

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        shift_en  = 1'b0;
        shift_in  = '0;
        emit      = 1'b0;
        emit_last = 1'b0;
        clear_row = 1'b0;
        rdy_d     = 1'b1;
        case (state_q)
            RUN: begin
                if (accept) begin
                    shift_en = 1'b1;
                    shift_in = bus.pix;
                    emit     = (count_q >= EMIT_IDX);
`ifdef STREAM_WINDOW_ZERO_PAD_EN
                    if (bus.pix_last) begin
                        state_d = FLUSH;
                        rdy_d   = 1'b0;
                    end
`else
                    emit_last = bus.pix_last;
                    clear_row = bus.pix_last;
`endif
                end
            end
`ifdef STREAM_WINDOW_ZERO_PAD_EN
            FLUSH: begin
                shift_en = 1'b1;
                emit     = (count_q >= EMIT_IDX);
                rdy_d    = 1'b0;
                if (flush_q == FLUSH_END) begin
                    state_d   = RUN;
                    emit_last = 1'b1;
                    clear_row = 1'b1;
                    rdy_d     = 1'b1;
                end
            end
`endif
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the window register is reset because a partial row must never leak into the next one.
            sr_q    <= '0;
            count_q <= '0;
            img_q   <= '0;
            val_q   <= 1'b0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef STREAM_WINDOW_ZERO_PAD_EN
            flush_q <= '0;
`endif
        end else begin
            rdy_q  <= rdy_d;
            val_q  <= emit;
            last_q <= emit && emit_last;
            if (emit) img_q <= shifted;
            if (clear_row) begin
                sr_q    <= '0;
                count_q <= '0;
            end else if (shift_en) begin
                sr_q <= shifted;
                if (count_q != COUNT_MAX) count_q <= count_q + CW'(1);
            end
`ifdef STREAM_WINDOW_ZERO_PAD_EN
            if (state_q == FLUSH) flush_q <= flush_q + FW'(1);
            else                  flush_q <= '0;
`endif
        end
    end

    assign bus.pix_rdy = rdy_q;
    assign bus.img     = img_q;
    assign bus.val     = val_q;
    assign bus.last    = last_q;
endmodule

// File: tb/tb_stream_window.sv
// Randomized bench for stream_window: a row-buffer reference model predicts img/val/last/pix_rdy
// every cycle. Works for both the default build and STREAM_WINDOW_ZERO_PAD_EN.
module tb_stream_window;
    localparam int W  = 16;
    localparam int NB = 3;
    localparam int H  = (NB - 1) / 2;
`ifdef STREAM_WINDOW_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    typedef logic [W-1:0] pq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b0;

    stream_window_if #(.IMG_WIDTH(W), .IMG_NB(NB)) bus ();
    stream_window #(.IMG_WIDTH(W), .IMG_NB(NB)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the pixels of the current row, and how many flush beats remain.
    logic [W-1:0]    row[$];
    int              flush_left = 0;
    logic            exp_rdy  = 1'b0;
    logic            exp_val  = 1'b0;
    logic            exp_last = 1'b0;
    logic [W*NB-1:0] exp_img  = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Window centred on row pixel c; positions outside the row read as zero.
    function automatic logic [W*NB-1:0] window_at(input int c);
        logic [W*NB-1:0] w = '0;
        for (int k = 0; k < NB; k++) begin
            int idx = c - H + k;
            if (idx >= 0 && idx < row.size()) w[k*W +: W] = row[idx];
        end
        return w;
    endfunction

    function automatic pq_t seq(input int start, input int n);
        pq_t q;
        for (int i = 0; i < n; i++) q.push_back(W'(start + i));
        return q;
    endfunction

    task automatic model_reset();
        row.delete();
        flush_left = 0;
        exp_rdy    = 1'b0;
        exp_val    = 1'b0;
        exp_last   = 1'b0;
        exp_img    = '0;
    endtask

    // Drive one cycle of inputs (called at a falling edge), predict, and compare at the next falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] p, input logic l, output logic acc);
        bus.pix_val  = v;
        bus.pix      = p;
        bus.pix_last = l;
        acc = 1'b0;
        if (!rst) begin
            model_reset();
        end else begin
            exp_val  = 1'b0;
            exp_last = 1'b0;
            if (exp_rdy && v) begin
                int i;
                acc = 1'b1;
                row.push_back(p);
                i = row.size() - 1;
                if (i >= (ZP ? H : NB - 1)) begin
                    exp_img  = window_at(i - H);
                    exp_val  = 1'b1;
                    exp_last = !ZP && l;
                end
                if (l) begin
                    if (ZP) flush_left = H;
                    else    row.delete();
                end
            end else if (flush_left > 0) begin
                int c;
                c = row.size() - flush_left;
                if (c >= 0) begin
                    exp_img  = window_at(c);
                    exp_val  = 1'b1;
                    exp_last = (flush_left == 1);
                end
                flush_left--;
                if (flush_left == 0) row.delete();
            end
            exp_rdy = (flush_left == 0);
        end
        @(negedge clk);
        check("img", bus.img, exp_img);
        check("val", bus.val, exp_val);
        check("last", bus.last, exp_last);
        check("pix_rdy", bus.pix_rdy, exp_rdy);
    endtask

    // Idle cycles carry junk on pix/pix_last to show they are ignored without pix_val.
    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, W'($urandom), 1'($urandom), acc);
    endtask

    task automatic send_row(input pq_t px, input int min_gap, input int max_gap, input bit end_row);
        for (int n = 0; n < px.size(); n++) begin
            logic acc;
            int   tries;
            if (max_gap > 0) idle($urandom_range(max_gap, min_gap));
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 8) begin
                cycle(1'b1, px[n], end_row && (n == px.size() - 1), acc);
                tries++;
            end
            if (!acc) check("accept_timeout", acc, 1);
        end
    endtask

    // Reset between clock edges must clear the outputs without waiting for a clock.
    task automatic async_reset();
        logic acc;
        #2;
        rst = 1'b0;
        #1;
        check("areset_img", bus.img, 0);
        check("areset_val", bus.val, 0);
        check("areset_last", bus.last, 0);
        check("areset_rdy", bus.pix_rdy, 0);
        model_reset();
        @(negedge clk);
        cycle(1'b1, W'($urandom), 1'b0, acc);
        cycle(1'b0, W'($urandom), 1'b0, acc);
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0, acc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        pq_t  q;
        bus.pix_val  = 1'b0;
        bus.pix      = '0;
        bus.pix_last = 1'b0;

        // Held in reset with pix_val toggling, then released.
        for (int i = 0; i < 6; i++) cycle(i[0], W'(i + 1), 1'b0, acc);
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0, acc);

        send_row(seq(1, 5), 0, 0, 1'b1);
        idle(3);
        send_row(seq(1, 5), 2, 20, 1'b1);
        idle(3);
        send_row(seq(1, 2), 0, 0, 1'b1);
        send_row(seq(7, 3), 0, 0, 1'b1);
        idle(3);
        send_row(seq(1, 3), 0, 0, 1'b1);
        send_row(seq(5, 1), 0, 0, 1'b1);
        idle(3);

        // Reset mid-row, then reset right after a row end (mid-flush in same-size mode).
        send_row(seq(20, 4), 0, 0, 1'b0);
        async_reset();
        send_row(seq(10, 3), 0, 0, 1'b1);
        async_reset();
        send_row(seq(4, 3), 0, 0, 1'b1);
        idle(3);

        repeat (40) begin
            int n;
            n = $urandom_range(8, 1);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(W'($urandom));
            send_row(q, 0, $urandom_range(3, 0), 1'b1);
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stream_window.md
# stream_window

Sliding-window generator feeding the convolution MAC stage. Accepts a serial pixel stream, one pixel per accepted beat, grouped into rows by a last flag, and emits packed windows of `IMG_NB` consecutive same-row pixels on the `img`/`val` bus the MAC stage consumes. Windows never span a row boundary. Optional zero padding at row edges yields one window per input pixel.

## Interface
- `IMG_WIDTH`, 16, pixel width in bits
- `IMG_NB`, 3, window length in pixels; odd, >= 3; halo H = (IMG_NB-1)/2

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `pix`  in  IMG_WIDTH  input pixel
- `pix_val`  in  1  pixel valid
- `pix_last`  in  1  qualifies `pix` as final pixel of its row
- `pix_rdy`  out  1  block can accept; beat accepted when `pix_val && pix_rdy`
- `img`  out  IMG_WIDTH*IMG_NB  window; slot k at `img[k*IMG_WIDTH +: IMG_WIDTH]`, slot 0 oldest
- `val`  out  1  window valid, single-cycle pulse per window
- `last`  out  1  qualifies final window of a row; only with `val`

## Operation
- Shift register of IMG_NB pixels: an accepted pixel enters slot IMG_NB-1 and older contents move toward slot 0.
- Per-row count, saturating at IMG_NB. Cleared, and shift register zeroed, when an accepted beat has `pix_last`.
- States: RUN (accepting), FLUSH (ZERO_PAD_EN only).
- Valid mode (no macro): window emitted after each accepted pixel with in-row index >= IMG_NB-1. A row of N pixels gives max(0, N-IMG_NB+1) windows. `last` accompanies the window produced by the `pix_last` beat. Rows with N < IMG_NB produce no `val` and no `last`. `pix_rdy` is always 1 outside reset.
- Beats with `pix_val` while `pix_rdy` = 0 are ignored; no state change.
- `img` holds its value between windows; only `val`/`last` pulse.

## Timing
- Reset values: `img` = 0, `val` = 0, `last` = 0, `pix_rdy` = 0, state RUN, count 0, shift register 0.
- `pix_rdy` rises on the first `clk` edge after `rst` deasserts.
- Latency: window registered on the edge that accepts its completing pixel; `val` high the following cycle.
- Back-to-back acceptance sustains one window per cycle.
- Reset asserted mid-row or mid-flush discards the partial row. The first post-reset pixel is index 0.

## Configuration
- `STREAM_WINDOW_ZERO_PAD_EN` defined: same-size mode.
  - Row starts with H implicit zeros left of pixel 0. Window centred on pixel j emits when pixel j+H is accepted.
  - On acceptance of `pix_last`, `pix_rdy` is registered low. The block enters FLUSH for exactly H cycles, shifting in a zero each cycle.
  - Each FLUSH cycle emits a window only if its centre index >= 0. The final FLUSH window carries `last`.
  - A row of N >= 1 pixels yields exactly N windows. `pix_rdy` returns high on the edge ending FLUSH.
- Undefined: valid mode as above. No FLUSH state; `pix_rdy` is constant 1 after reset.

## Test plan
(IMG_NB = 3, IMG_WIDTH = 16; windows listed slot0,slot1,slot2)
- Reset: hold `rst` low 6 cycles with `pix_val` toggling -> `img` = 0, `val` = 0, `last` = 0, `pix_rdy` = 0 throughout; `pix_rdy` = 1 one edge after release.
- Valid mode, continuous row 1,2,3,4,5 (last on 5) -> windows (1,2,3), (2,3,4), (3,4,5) on consecutive cycles. First `val` one cycle after pixel 3 accepted; `last` only with (3,4,5).
- Valid mode, same row with 2–20 idle cycles between beats -> identical windows, each `val` exactly one cycle after its completing beat, `img` stable across gaps.
- Valid mode, short row 1,2 (last) then 7,8,9 (last) -> no `val` for the first row; single window (7,8,9) with `last`, no 1/2 contamination.
- ZERO_PAD_EN, row 1,2,3 (last) -> (0,1,2), (1,2,3), (2,3,0)+`last`. `pix_rdy` low exactly 1 cycle after last beat; a `pix_val` pulse then is ignored. Single-pixel row 5 (last) -> one window (0,5,0)+`last`.
- ZERO_PAD_EN, `rst` asserted during FLUSH -> outputs zero immediately (async). Next row 4,5,6 (last) -> (0,4,5), (4,5,6), (5,6,0)+`last`.
